// File: rtl/mnist_frame_ctrl.sv
// Frame sequencer for the MNIST pipeline: streams one image from a synchronous
// RAM into the pipeline, waits for the single result beat, then runs a
// sequential signed argmax over the class scores.
module mnist_frame_ctrl #(
  parameter int N         = 8,
  parameter int IMG_SIZE  = 28,
  parameter int NUM_CLASS = 10,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             class_out,
  output logic [N-1:0]           class_score,
  output logic                   timeout_err,
  output logic                   img_rd_en,
  output logic [ADDR_W-1:0]      img_rd_addr,
  input  logic [N-1:0]           img_rd_data,
  output logic                   pix_vld,
  output logic [N-1:0]           pix_dout,
  input  logic [NUM_CLASS*N-1:0] net_dout,
  input  logic                   net_dout_vld,
  input  logic                   net_dout_end
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FEED   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ARGMAX = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int                WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]        LAST_CLS = 4'(NUM_CLASS - 1);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [3:0]          cls_q, cls_d;
  logic signed [N-1:0] scores_q [NUM_CLASS];
  logic signed [N-1:0] scores_d [NUM_CLASS];
  logic signed [N-1:0] best_q, best_d;
  logic [3:0]          best_idx_q, best_idx_d;
  logic [3:0]          class_out_q, class_out_d;
  logic signed [N-1:0] class_score_q, class_score_d;
  logic                timeout_err_q, timeout_err_d;
  logic                pix_vld_q, pix_vld_d;

  logic signed [N-1:0] cand, nb_val;
  logic [3:0]          nb_idx;
  logic                take;

  // Next-state and datapath decisions for the whole frame sequence.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wd_d          = wd_q;
    cls_d         = cls_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    class_out_d   = class_out_q;
    class_score_d = class_score_q;
    timeout_err_d = timeout_err_q;
    for (int k = 0; k < NUM_CLASS; k++) scores_d[k] = scores_q[k];
    cand   = scores_q[cls_q];
    take   = (cls_q == 4'd0) || (cand > best_q);
    nb_val = take ? cand : best_q;
    nb_idx = take ? cls_q : best_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_FEED;
          pix_cnt_d     = '0;
          timeout_err_d = 1'b0;
          class_out_d   = '0;
          class_score_d = '0;
          for (int k = 0; k < NUM_CLASS; k++) scores_d[k] = '0;
        end
      end
      S_FEED: begin
        // Counter parks on the last address instead of wrapping.
        if (pix_cnt_q == LAST_PIX) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A result beat takes priority over the watchdog in the same cycle.
        if (net_dout_vld) begin
          for (int k = 0; k < NUM_CLASS; k++) scores_d[k] = net_dout[k*N +: N];
          cls_d   = '0;
          state_d = S_ARGMAX;
        end else if (wd_q == WD_LAST) begin
          class_out_d   = 4'hF;
          class_score_d = '0;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        best_d     = nb_val;
        best_idx_d = nb_idx;
        if (cls_q == LAST_CLS) begin
          class_out_d   = nb_idx;
          class_score_d = nb_val;
          state_d       = S_DONE;
        end else begin
          cls_d = cls_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The RAM output is valid one cycle after the read, so the valid strobe lags by one.
  always_comb pix_vld_d = (state_q == S_FEED);

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      wd_q          <= '0;
      cls_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      class_out_q   <= '0;
      class_score_q <= '0;
      timeout_err_q <= 1'b0;
      pix_vld_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wd_q          <= wd_d;
      cls_q         <= cls_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      class_out_q   <= class_out_d;
      class_score_q <= class_score_d;
      timeout_err_q <= timeout_err_d;
      pix_vld_q     <= pix_vld_d;
    end
  end

  // Captured score bank.
  always_ff @(posedge clk) begin
    // NOTE: the score bank has no reset; it is cleared by an accepted start
    // and only read in ARGMAX after a capture, so reset would add nothing.
    for (int k = 0; k < NUM_CLASS; k++) scores_q[k] <= scores_d[k];
  end

  // A result beat is expected to be the final beat of the frame.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == S_WAIT && net_dout_vld) |-> net_dout_end);

  assign busy        = (state_q == S_FEED) || (state_q == S_WAIT) || (state_q == S_ARGMAX);
  assign done        = (state_q == S_DONE);
  assign img_rd_en   = (state_q == S_FEED);
  assign img_rd_addr = pix_cnt_q;
  assign pix_vld     = pix_vld_q;
  assign pix_dout    = pix_vld_q ? img_rd_data : '0;
  assign class_out   = class_out_q;
  assign class_score = class_score_q;
  assign timeout_err = timeout_err_q;

endmodule
